// File: rtl/control_unit_md_if.sv
// Mul/div sequencing handshake between the control unit and the mul/div
// unit / hazard unit.
//   MulDiv_E  : E stage holds an RV32M op
//   md_op_E   : funct3 of that op (0-3 mul family, 4-7 div/rem)
//   md_start  : one-cycle start pulse to the mul/div unit
//   md_done   : one-cycle pulse in the final cycle of the op (result valid)
//   MDStall   : stall request for F, D and E
interface control_unit_md_if;
  logic       MulDiv_E;
  logic [2:0] md_op_E;
  logic       md_start;
  logic       md_done;
  logic       MDStall;

  modport master (output MulDiv_E, output md_op_E, output md_start,
                  output md_done, output MDStall);
  modport slave  (input MulDiv_E, input md_op_E, input md_start,
                  input md_done, input MDStall);
endinterface

// File: rtl/control_unit_md.sv
// Pipelined control unit with RV32M sequencing.
// Decodes the D-stage instruction (RV32I + MUL/DIV/REM), registers the
// control word into E, and holds multi-cycle M ops in E with a counter
// sequencer that drives the mul/div unit and stalls the front of the pipe.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   opcode/funct7/funct3  : D-stage instruction fields
//   valid_D               : D instruction valid (0 = bubble)
//   Flush_E               : bubble request for E (ignored while stalling)
//   ImmSrc_D              : combinational immediate select
//   *_E                   : registered E-stage control
//   md                    : mul/div handshake (control_unit_md_if.master)

// Main decoder: opcode -> datapath control.
// ALUSrcA: 00 rs1, 01 PC (auipc), 10 zero (lui).
// ResultSrc: 00 ALU/MD, 01 memory, 10 PC+4.
// ImmSrc: 00 I, 01 S, 10 B, 11 J; U-type immediates are formed by the
// extender from the opcode, so lui/auipc report 00.
module main_decoder #(
  parameter int RESULTSRC_WIDTH = 2,
  parameter int IMMSRC_WIDTH    = 2,
  parameter int OPCODE_WIDTH    = 7
) (
  input  logic [OPCODE_WIDTH-1:0]    op,
  output logic                       reg_write,
  output logic [IMMSRC_WIDTH-1:0]    imm_src,
  output logic [1:0]                 alu_src_a,
  output logic                       alu_src_b,
  output logic                       mem_write,
  output logic [RESULTSRC_WIDTH-1:0] result_src,
  output logic                       branch,
  output logic [1:0]                 alu_op,
  output logic                       jump,
  output logic                       pc_jal_src
);
  always_comb begin
    reg_write  = 1'b0;
    imm_src    = '0;
    alu_src_a  = 2'b00;
    alu_src_b  = 1'b0;
    mem_write  = 1'b0;
    result_src = '0;
    branch     = 1'b0;
    alu_op     = 2'b00;
    jump       = 1'b0;
    pc_jal_src = 1'b0;
    case (op)
      OPCODE_WIDTH'(7'b0000011): begin // load
        reg_write  = 1'b1;
        alu_src_b  = 1'b1;
        result_src = RESULTSRC_WIDTH'(2'b01);
      end
      OPCODE_WIDTH'(7'b0100011): begin // store
        imm_src   = IMMSRC_WIDTH'(2'b01);
        alu_src_b = 1'b1;
        mem_write = 1'b1;
      end
      OPCODE_WIDTH'(7'b0110011): begin // R-type
        reg_write = 1'b1;
        alu_op    = 2'b10;
      end
      OPCODE_WIDTH'(7'b0010011): begin // I-type ALU
        reg_write = 1'b1;
        alu_src_b = 1'b1;
        alu_op    = 2'b10;
      end
      OPCODE_WIDTH'(7'b1100011): begin // branch
        imm_src = IMMSRC_WIDTH'(2'b10);
        branch  = 1'b1;
        alu_op  = 2'b01;
      end
      OPCODE_WIDTH'(7'b1101111): begin // jal
        reg_write  = 1'b1;
        imm_src    = IMMSRC_WIDTH'(2'b11);
        result_src = RESULTSRC_WIDTH'(2'b10);
        jump       = 1'b1;
      end
      OPCODE_WIDTH'(7'b1100111): begin // jalr: target comes from the ALU
        reg_write  = 1'b1;
        alu_src_b  = 1'b1;
        result_src = RESULTSRC_WIDTH'(2'b10);
        jump       = 1'b1;
        pc_jal_src = 1'b1;
      end
      OPCODE_WIDTH'(7'b0110111): begin // lui
        reg_write = 1'b1;
        alu_src_a = 2'b10;
        alu_src_b = 1'b1;
      end
      OPCODE_WIDTH'(7'b0010111): begin // auipc
        reg_write = 1'b1;
        alu_src_a = 2'b01;
        alu_src_b = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// ALU decoder. Codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU,
// 7 SLL, 8 SRL, 9 SRA.
module alu_decoder #(
  parameter int ALUCONTROL_WIDTH = 4
) (
  input  logic                        opb5,
  input  logic [2:0]                  funct3,
  input  logic                        funct7b5,
  input  logic [1:0]                  alu_op,
  output logic [ALUCONTROL_WIDTH-1:0] alu_control
);
  always_comb begin
    alu_control = '0;
    case (alu_op)
      2'b00: alu_control = ALUCONTROL_WIDTH'(0);
      2'b01: alu_control = ALUCONTROL_WIDTH'(1);
      default: begin
        case (funct3)
          // funct7b5 only means SUB for R-type; I-type uses that bit as imm
          3'b000:  alu_control = ALUCONTROL_WIDTH'((opb5 && funct7b5) ? 1 : 0);
          3'b001:  alu_control = ALUCONTROL_WIDTH'(7);
          3'b010:  alu_control = ALUCONTROL_WIDTH'(5);
          3'b011:  alu_control = ALUCONTROL_WIDTH'(6);
          3'b100:  alu_control = ALUCONTROL_WIDTH'(4);
          3'b101:  alu_control = ALUCONTROL_WIDTH'(funct7b5 ? 9 : 8);
          3'b110:  alu_control = ALUCONTROL_WIDTH'(3);
          default: alu_control = ALUCONTROL_WIDTH'(2);
        endcase
      end
    endcase
  end
endmodule

module control_unit_md #(
  parameter int RESULTSRC_WIDTH  = 2,
  parameter int ALUCONTROL_WIDTH = 4,
  parameter int IMMSRC_WIDTH     = 2,
  parameter int OPCODE_WIDTH     = 7,
  parameter int FUNCT7_WIDTH     = 7,
  parameter int FUNCT3_WIDTH     = 3,
  parameter int MUL_CYCLES       = 2,
  parameter int DIV_CYCLES       = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [OPCODE_WIDTH-1:0]     opcode,
  input  logic [FUNCT7_WIDTH-1:0]     funct7,
  input  logic [FUNCT3_WIDTH-1:0]     funct3,
  input  logic                        valid_D,
  input  logic                        Flush_E,
  output logic [IMMSRC_WIDTH-1:0]     ImmSrc_D,
  output logic                        RegWrite_E,
  output logic                        MemWrite_E,
  output logic                        Jump_E,
  output logic                        Branch_E,
  output logic                        ALUSrcB_E,
  output logic                        PCJalSrc_E,
  output logic [RESULTSRC_WIDTH-1:0]  ResultSrc_E,
  output logic [ALUCONTROL_WIDTH-1:0] ALUControl_E,
  output logic [1:0]                  ALUSrcA_E,
  output logic [1:0]                  write_type_E,
  control_unit_md_if.master           md
);
  localparam int MAX_LAT = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  typedef struct packed {
    logic                        reg_write;
    logic                        mem_write;
    logic                        jump;
    logic                        branch;
    logic                        alu_src_b;
    logic                        pc_jal_src;
    logic [RESULTSRC_WIDTH-1:0]  result_src;
    logic [ALUCONTROL_WIDTH-1:0] alu_control;
    logic [1:0]                  alu_src_a;
    logic [1:0]                  write_type;
    logic                        mul_div;
    logic [2:0]                  md_op;
  } ectl_t;

  // D-stage decode
  logic                        rw_m, asb_m, mw_m, br_m, j_m, pcj_m;
  logic [1:0]                  asa_m, aluop_m;
  logic [RESULTSRC_WIDTH-1:0]  rs_m;
  logic [ALUCONTROL_WIDTH-1:0] aluctl_m;
  logic                        is_m_op;
  ectl_t                       dec;

  main_decoder #(
    .RESULTSRC_WIDTH (RESULTSRC_WIDTH),
    .IMMSRC_WIDTH    (IMMSRC_WIDTH),
    .OPCODE_WIDTH    (OPCODE_WIDTH)
  ) u_main_dec (
    .op         (opcode),
    .reg_write  (rw_m),
    .imm_src    (ImmSrc_D),
    .alu_src_a  (asa_m),
    .alu_src_b  (asb_m),
    .mem_write  (mw_m),
    .result_src (rs_m),
    .branch     (br_m),
    .alu_op     (aluop_m),
    .jump       (j_m),
    .pc_jal_src (pcj_m)
  );

  alu_decoder #(
    .ALUCONTROL_WIDTH (ALUCONTROL_WIDTH)
  ) u_alu_dec (
    .opb5        (opcode[5]),
    .funct3      (funct3[2:0]),
    .funct7b5    (funct7[5]),
    .alu_op      (aluop_m),
    .alu_control (aluctl_m)
  );

  assign is_m_op = (opcode == OPCODE_WIDTH'(7'b0110011)) &&
                   (funct7 == FUNCT7_WIDTH'(7'b0000001));

  always_comb begin
    dec             = '0;
    dec.reg_write   = rw_m;
    dec.mem_write   = mw_m;
    dec.jump        = j_m;
    dec.branch      = br_m;
    dec.alu_src_b   = asb_m;
    dec.pc_jal_src  = pcj_m;
    dec.result_src  = rs_m;
    dec.alu_control = aluctl_m;
    dec.alu_src_a   = asa_m;
    dec.write_type  = mw_m ? funct3[1:0] : 2'b00;
    if (is_m_op) begin
      // Result returns on the ALU/MD path; ALU is idle for M ops.
      dec.reg_write   = 1'b1;
      dec.result_src  = '0;
      dec.alu_control = '0;
      dec.mul_div     = 1'b1;
      dec.md_op       = funct3[2:0];
    end
  end

  // D -> E boundary and mul/div sequencer
  ectl_t            e_q, e_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] lat_m1;
  logic             md_start_w, md_done_w, md_stall_w;

  assign lat_m1     = e_q.md_op[2] ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);
  assign md_start_w = (state_q == IDLE) && e_q.mul_div;
  assign md_done_w  = (state_q == BUSY) && (cnt_q == '0);
  assign md_stall_w = e_q.mul_div && !md_done_w;

  always_comb begin
    // Hold beats flush: an op in flight must keep its control word.
    e_d = e_q;
    if (!md_stall_w) begin
      if (Flush_E || !valid_D) e_d = '0;
      else                     e_d = dec;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (e_q.mul_div) begin
          state_d = BUSY;
          cnt_d   = lat_m1;
        end
      end
      default: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        else             state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e_q     <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      e_q     <= e_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign RegWrite_E   = e_q.reg_write;
  assign MemWrite_E   = e_q.mem_write;
  assign Jump_E       = e_q.jump;
  assign Branch_E     = e_q.branch;
  assign ALUSrcB_E    = e_q.alu_src_b;
  assign PCJalSrc_E   = e_q.pc_jal_src;
  assign ResultSrc_E  = e_q.result_src;
  assign ALUControl_E = e_q.alu_control;
  assign ALUSrcA_E    = e_q.alu_src_a;
  assign write_type_E = e_q.write_type;

  assign md.MulDiv_E = e_q.mul_div;
  assign md.md_op_E  = e_q.md_op;
  assign md.md_start = md_start_w;
  assign md.md_done  = md_done_w;
  assign md.MDStall  = md_stall_w;
endmodule

// File: doc/control_unit_md.md
# control_unit_md

Pipelined control unit with RV32M sequencing for the 5-stage RISC-V core. It decodes the instruction in the D stage (RV32I base plus RV32M MUL/DIV/REM) and registers all control signals into the E stage. It replaces the purely combinational control path. It runs a counter-based sequencer that holds multi-cycle multiply/divide ops in E, drives the external mul/div unit, and raises a stall to the hazard unit until the op completes.

## Interface
Parameters:
- RESULTSRC_WIDTH, 2, ResultSrc width
- ALUCONTROL_WIDTH, 4, ALUControl width
- IMMSRC_WIDTH, 2, ImmSrc width
- OPCODE_WIDTH / FUNCT7_WIDTH / FUNCT3_WIDTH, 7/7/3, instruction field widths
- MUL_CYCLES, 2, mul-unit latency in cycles, legal range ≥1
- DIV_CYCLES, 32, div-unit latency in cycles, legal range ≥1; counter width = $clog2(max(MUL_CYCLES,DIV_CYCLES))+1

Ports:
- clk, in, 1, single clock
- rst, in, 1, synchronous active-high reset
- opcode / funct7 / funct3, in, 7/7/3, D-stage instruction fields
- valid_D, in, 1, D-stage instruction valid; 0 decodes as bubble
- Flush_E, in, 1, hazard-unit request to bubble E
- ImmSrc_D, out, IMMSRC_WIDTH, combinational immediate select (D stage)
- RegWrite_E, MemWrite_E, Jump_E, Branch_E, ALUSrcB_E, PCJalSrc_E, out, 1 each, registered control
- ResultSrc_E, out, RESULTSRC_WIDTH; ALUControl_E, out, ALUCONTROL_WIDTH; ALUSrcA_E, out, 2; write_type_E, out, 2, registered control
- MulDiv_E, out, 1, E holds an M-extension op
- md_op_E, out, 3, funct3 of the M op (0–3 mul family, 4–7 div/rem)
- md_start, out, 1, one-cycle start pulse to the mul/div unit
- md_done, out, 1, one-cycle pulse in the final cycle of the op; result valid
- MDStall, out, 1, stall request to the hazard unit for F, D and E

## Operation
- D decode: the existing main_decoder and ALU_decoder are instantiated unchanged for RV32I. M op = opcode 0110011 with funct7 0000001. For an M op: RegWrite=1, ResultSrc=00 (ALU/MD path), MulDiv=1, and ALUControl is don't-care and forced to 0.
- E register update priority: rst > MDStall (hold) > Flush_E or !valid_D (bubble, all fields 0) > capture D.
- Flush_E is ignored while MDStall=1. Hold wins.
- Sequencer states: IDLE and BUSY. LAT = MUL_CYCLES if md_op_E[2]=0, else DIV_CYCLES.
- IDLE with MulDiv_E=1: md_start=1, cnt←LAT-1, go to BUSY.
- BUSY with cnt≠0: cnt decrements.
- BUSY with cnt=0: md_done=1, go to IDLE.
- MDStall = MulDiv_E & !md_done (combinational).
- An M op occupies E for LAT+1 cycles, and MDStall is high for LAT of those cycles.
- Back-to-back M ops: the next op is captured on the md_done edge and starts from IDLE on the following cycle. There are no idle gap cycles beyond that.
- Non-M ops never enter BUSY. md_start, md_done and MDStall stay 0.

## Timing
- Reset: all *_E outputs, md_op_E, md_start, md_done and MDStall are 0. The state is IDLE and cnt is 0.
- Reset mid-op is a synchronous abort. On the next edge the state is IDLE, E is cleared and MDStall is 0. The mul/div unit ignores its in-flight op.
- Non-M op: D at cycle N gives its control on *_E in cycle N+1, i.e. one cycle latency.
- M op in D at N:
  - N+1: MulDiv_E=1, md_start=1, MDStall=1.
  - N+2 … N+LAT: BUSY, MDStall=1.
  - N+LAT+1: md_done=1, MDStall=0.
  - N+LAT+2: E holds the next instruction.
- With LAT=1: md_start at N+1, md_done at N+2.
- ImmSrc_D is purely combinational from the D fields.

## Test plan
- Reset: hold rst 3 cycles with an M op on the inputs -> every output is 0. After release, MDStall rises only when the op reaches E.
- ADD (0x00000033 fields, valid_D=1) -> next cycle RegWrite_E=1, ALUControl_E=ADD code, MulDiv_E=0, MDStall=0.
- MUL (funct7=0000001, funct3=000), MUL_CYCLES=2 -> md_start at N+1, MDStall high N+1..N+2, md_done at N+3, E advances at N+4.
- DIV (funct3=100), DIV_CYCLES=32 -> MDStall high exactly 32 cycles, one md_start, one md_done. A Flush_E pulse mid-op is ignored and the E contents are unchanged.
- Back-to-back MUL then REM -> second md_start is in the cycle after the first md_done. Total occupancy is 3+33 cycles.
- rst asserted at cycle 10 of a DIV -> next cycle IDLE, MDStall=0, MulDiv_E=0. No md_done pulse.
